// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder FSM states, block geometry and the
// block-count formula the padder and compression top must agree on.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEXT,
    ST_FETCH,
    ST_WAIT,
    ST_CAPTURE,
    ST_EMIT,
    ST_FIN
  } pad_state_t;

  localparam int         SHA_BLOCK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE        = 8'h80;

  // A message plus the 0x80 byte and 64-bit length fits in this many 512-bit blocks.
  function automatic logic [31:0] num_blocks(input logic [31:0] msg_bytes);
    return ((msg_bytes + 32'd8) >> 6) + 32'd1;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Forms padded word k from its source: raw memory word, masked tail word,
// the lone pad word, the length words or zero fill.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] i_k,
  input  logic [31:0] i_nfull,
  input  logic [1:0]  i_rem,
  input  logic [31:0] i_total,
  input  logic [31:0] i_size,
  input  logic [31:0] i_mem_word,
  output logic [31:0] o_word,
  output logic        o_needs_fetch
);

  logic [31:0] w_masked;

  // Byte 0 lives in the top byte, so the surviving message bytes are the upper rem bytes.
  always_comb begin
    w_masked = i_mem_word;
    case (i_rem)
      2'd1:    w_masked = {i_mem_word[31:24], PAD_BYTE, 16'h0000};
      2'd2:    w_masked = {i_mem_word[31:16], PAD_BYTE, 8'h00};
      2'd3:    w_masked = {i_mem_word[31:8], PAD_BYTE};
      default: w_masked = i_mem_word;
    endcase
  end

  always_comb begin
    o_word        = 32'h0000_0000;
    o_needs_fetch = 1'b0;
    if (i_k < i_nfull) begin
      o_word        = i_mem_word;
      o_needs_fetch = 1'b1;
    end else if (i_k == i_nfull) begin
      if (i_rem != 2'd0) begin
        o_word        = w_masked;
        o_needs_fetch = 1'b1;
      end else begin
        o_word = {PAD_BYTE, 24'h000000};
      end
    end else if (i_k == i_total - 32'd2) begin
      o_word = {29'd0, i_size[31:29]};
    end else if (i_k == i_total - 32'd1) begin
      o_word = {i_size[28:0], 3'b000};
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 front end: reads a byte message from word memory and streams the
// FIPS 180-4 padded words downstream over valid/ready.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       size,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [3:0]        out_idx,
  output logic              out_last_block,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  pad_state_t        r_state;
  pad_state_t        w_next_state;
  logic [31:0]       r_msg_addr;
  logic [31:0]       r_size;
  logic [31:0]       r_nfull;
  logic [1:0]        r_rem;
  logic [31:0]       r_total;
  logic [31:0]       r_k;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_out_word;
  logic [31:0]       w_addr_sum;
  logic [31:0]       w_pad_word;
  logic              w_needs_fetch;
  logic              w_unused_addr;

  assign mem_clk  = clk;
  assign mem_we   = 1'b0;
  assign mem_addr = r_mem_addr;
  assign out_word = r_out_word;
  assign out_idx  = r_k[3:0];

  // Only the low ADDR_W bits reach memory, so addresses wrap silently.
  assign w_addr_sum    = r_msg_addr + r_k;
  assign w_unused_addr = |(w_addr_sum >> ADDR_W);

  sha256_pad_word u_pad_word (
    .i_k           (r_k),
    .i_nfull       (r_nfull),
    .i_rem         (r_rem),
    .i_total       (r_total),
    .i_size        (r_size),
    .i_mem_word    (mem_read_data),
    .o_word        (w_pad_word),
    .o_needs_fetch (w_needs_fetch)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next_state = ST_NEXT;
      ST_NEXT:    w_next_state = w_needs_fetch ? ST_FETCH : ST_EMIT;
      ST_FETCH:   w_next_state = ST_WAIT;
      ST_WAIT:    w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_EMIT;
      ST_EMIT:    if (out_ready) w_next_state = (r_k == r_total - 32'd1) ? ST_FIN : ST_NEXT;
      ST_FIN:     w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid      = (r_state == ST_EMIT);
    busy           = (r_state != ST_IDLE) && (r_state != ST_FIN);
    done           = (r_state == ST_FIN);
    out_last_block = out_valid && (r_k >= r_total - 32'd16);
    out_last       = out_valid && (r_k == r_total - 32'd1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msg_addr <= '0;
      r_size     <= '0;
      r_nfull    <= '0;
      r_rem      <= '0;
      r_total    <= '0;
      r_k        <= '0;
      r_mem_addr <= '0;
      r_out_word <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_msg_addr <= message_addr;
            r_size     <= size;
            r_nfull    <= size >> 2;
            r_rem      <= size[1:0];
            r_total    <= num_blocks(size) << 4;
            r_k        <= '0;
          end
        end
        ST_NEXT:    if (!w_needs_fetch) r_out_word <= w_pad_word;
        ST_FETCH:   r_mem_addr <= w_addr_sum[ADDR_W-1:0];
        ST_CAPTURE: r_out_word <= w_pad_word;
        ST_EMIT:    if (out_ready) r_k <= r_k + 32'd1;
        default: ;
      endcase
    end
  end

endmodule
